// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one GCD engine among N requesters.
// Holds at most one request in flight: accept, issue, wait for result, respond.
module gcd_arbiter #(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_valid,
    input  logic [N*2*W-1:0]     req_data,
    output logic [N-1:0]         req_ready,
    output logic [N-1:0]         resp_valid,
    output logic [W-1:0]         resp_data,
    input  logic [N-1:0]         resp_ready,
    output logic                 gcd_in_valid,
    output logic [2*W-1:0]       gcd_in_data,
    input  logic                 gcd_in_ready,
    input  logic                 gcd_out_valid,
    input  logic [W-1:0]         gcd_out_data,
    output logic [15:0]          done_count
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   tag;
    logic [2*W-1:0]  pair_q;
    logic [W-1:0]    result_q;
    logic [15:0]     done_count_q;
    logic [15:0]     done_count_nxt;

    logic            grant_found;
    logic [PW-1:0]   grant_idx;
    logic [PW-1:0]   scan_idx;
    int              scan;
    logic            accept;
    logic            capture;
    logic            resp_fire;

    // Scan from rr_ptr upward; iterating backwards lets the nearest match win.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan        = 0;
        scan_idx    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            scan = int'(rr_ptr) + k;
            if (scan >= N) begin
                scan = scan - N;
            end
            scan_idx = PW'(scan);
            if (req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // req_ready is gated by reset so a held request cannot show a grant during reset.
    always_comb begin
        state_nxt    = state;
        req_ready    = '0;
        resp_valid   = '0;
        gcd_in_valid = 1'b0;
        accept       = 1'b0;
        capture      = 1'b0;
        resp_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && reset) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_nxt            = ISSUE;
                end
            end
            ISSUE: begin
                gcd_in_valid = 1'b1;
                if (gcd_in_ready) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (gcd_out_valid) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                resp_valid[tag] = 1'b1;
                if (resp_ready[tag]) begin
                    resp_fire = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign done_count_nxt = resp_fire ? done_count_q + 16'd1 : done_count_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr       <= '0;
            tag          <= '0;
            pair_q       <= '0;
            result_q     <= '0;
            done_count_q <= '0;
        end else begin
            if (accept) begin
                pair_q <= req_data[grant_idx*2*W +: 2*W];
                tag    <= grant_idx;
            end
            if (capture) begin
                result_q <= gcd_out_data;
            end
            if (resp_fire) begin
                rr_ptr <= (tag == PW'(N - 1)) ? '0 : tag + PW'(1);
            end
            done_count_q <= done_count_nxt;
        end
    end

    assign resp_data   = result_q;
    assign gcd_in_data = pair_q;
    assign done_count  = done_count_q;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter; the bench itself plays the GCD engine and
// every requester, comparing outputs against hand-computed values.
module tb_gcd_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic                 clk;
    logic                 reset;
    logic [N-1:0]         req_valid;
    logic [N*2*W-1:0]     req_data;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         resp_valid;
    logic [W-1:0]         resp_data;
    logic [N-1:0]         resp_ready;
    logic                 gcd_in_valid;
    logic [2*W-1:0]       gcd_in_data;
    logic                 gcd_in_ready;
    logic                 gcd_out_valid;
    logic [W-1:0]         gcd_out_data;
    logic [15:0]          done_count;

    int checks;
    int failures;

    gcd_arbiter #(.N(N), .W(W)) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_ready    (resp_ready),
        .gcd_in_valid  (gcd_in_valid),
        .gcd_in_data   (gcd_in_data),
        .gcd_in_ready  (gcd_in_ready),
        .gcd_out_valid (gcd_out_valid),
        .gcd_out_data  (gcd_out_data),
        .done_count    (done_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Engine stand-in: waits for an issue, accepts it, then returns the GCD after 'compute' cycles.
    task automatic do_engine(input int compute);
        int guard;
        logic [W-1:0] a;
        logic [W-1:0] b;
        guard = 0;
        while (gcd_in_valid !== 1'b1 && guard < 20) begin
            @(negedge clk); #1;
            guard++;
        end
        checks++;
        if (gcd_in_valid !== 1'b1) begin
            failures++;
            $display("[TB] FAIL engine_issue_timeout gcd_in_valid=%b expected=1", gcd_in_valid);
            return;
        end
        {a, b} = gcd_in_data;
        @(negedge clk); #1;
        repeat (compute) @(negedge clk);
        gcd_out_valid = 1'b1;
        gcd_out_data  = gcd_fn(a, b);
        @(negedge clk); #1;
        gcd_out_valid = 1'b0;
    endtask

    task automatic apply_reset();
        reset         = 1'b0;
        req_valid     = '0;
        resp_ready    = '0;
        gcd_in_ready  = 1'b1;
        gcd_out_valid = 1'b0;
        gcd_out_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        req_data      = '0;
        req_valid     = 4'b1111;
        resp_ready    = '0;
        gcd_in_ready  = 1'b1;
        gcd_out_valid = 1'b0;
        gcd_out_data  = '0;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL reset_req_ready got=%b expected=0000", req_ready);
        end
        checks++;
        if (resp_valid !== 4'b0000 || resp_data !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL reset_resp got=%b/%h expected=0000/0000", resp_valid, resp_data);
        end
        checks++;
        if (gcd_in_valid !== 1'b0 || gcd_in_data !== 32'h0 || done_count !== 16'h0) begin
            failures++;
            $display("[TB] FAIL reset_engine_count got=%b/%h/%h expected=0/0/0",
                     gcd_in_valid, gcd_in_data, done_count);
        end
        req_valid = '0;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_single();
        req_data[31:0] = 32'h0030_0020;
        req_valid      = 4'b0001;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL single_grant got=%b expected=0001", req_ready);
        end
        @(negedge clk); #1;
        req_valid = '0;
        checks++;
        if (req_ready !== 4'b0000 || gcd_in_valid !== 1'b1 || gcd_in_data !== 32'h0030_0020) begin
            failures++;
            $display("[TB] FAIL single_issue got=%b/%b/%h expected=0000/1/00300020",
                     req_ready, gcd_in_valid, gcd_in_data);
        end
        @(negedge clk); #1;
        checks++;
        if (gcd_in_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL single_wait_in_valid got=%b expected=0", gcd_in_valid);
        end
        gcd_out_valid = 1'b1;
        gcd_out_data  = 16'h0010;
        @(negedge clk); #1;
        gcd_out_valid = 1'b0;
        checks++;
        if (resp_valid !== 4'b0001 || resp_data !== 16'h0010) begin
            failures++;
            $display("[TB] FAIL single_resp got=%b/%h expected=0001/0010", resp_valid, resp_data);
        end
        resp_ready = 4'b0001;
        @(negedge clk); #1;
        resp_ready = '0;
        checks++;
        if (resp_valid !== 4'b0000 || done_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL single_done got=%b/%0d expected=0000/1", resp_valid, done_count);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_data [4];
        logic [3:0]  exp_onehot;
        exp_data[0] = 16'h0010;
        exp_data[1] = 16'h0009;
        exp_data[2] = 16'h0001;
        exp_data[3] = 16'h0019;
        apply_reset();
        req_data   = {32'h0064_004B, 32'h0007_0005, 32'h001B_0009, 32'h0030_0020};
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            exp_onehot = 4'b0001 << i;
            #1;
            checks++;
            if (req_ready !== exp_onehot) begin
                failures++;
                $display("[TB] FAIL rr_grant_%0d got=%b expected=%b", i, req_ready, exp_onehot);
            end
            do_engine(1);
            checks++;
            if (resp_valid !== exp_onehot || resp_data !== exp_data[i]) begin
                failures++;
                $display("[TB] FAIL rr_resp_%0d got=%b/%h expected=%b/%h",
                         i, resp_valid, resp_data, exp_onehot, exp_data[i]);
            end
            @(negedge clk); #1;
        end
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL rr_wraparound got=%b expected=0001", req_ready);
        end
        req_valid  = '0;
        resp_ready = '0;
        checks++;
        if (done_count !== 16'd4) begin
            failures++;
            $display("[TB] FAIL rr_done_count got=%0d expected=4", done_count);
        end
    endtask

    task automatic test_backpressure();
        req_data[63:32] = 32'h0012_000C;
        req_valid       = 4'b0010;
        #1;
        do_engine(2);
        req_valid  = 4'b1111;
        resp_ready = 4'b1101;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (resp_valid !== 4'b0010 || resp_data !== 16'h0006 ||
                req_ready !== 4'b0000 || gcd_in_valid !== 1'b0) begin
                failures++;
                $display("[TB] FAIL backpressure_hold_%0d got=%b/%h/%b/%b expected=0010/0006/0000/0",
                         i, resp_valid, resp_data, req_ready, gcd_in_valid);
            end
            @(negedge clk); #1;
        end
        req_valid  = '0;
        resp_ready = 4'b0010;
        @(negedge clk); #1;
        resp_ready = '0;
        checks++;
        if (resp_valid !== 4'b0000 || done_count !== 16'd5) begin
            failures++;
            $display("[TB] FAIL backpressure_done got=%b/%0d expected=0000/5", resp_valid, done_count);
        end
    endtask

    task automatic test_engine_stall();
        req_data[127:96] = 32'h0064_004B;
        req_valid        = 4'b1000;
        gcd_in_ready     = 1'b0;
        @(negedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (gcd_in_valid !== 1'b1 || gcd_in_data !== 32'h0064_004B) begin
                failures++;
                $display("[TB] FAIL stall_hold_%0d got=%b/%h expected=1/0064004b",
                         i, gcd_in_valid, gcd_in_data);
            end
            @(negedge clk); #1;
        end
        gcd_in_ready = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (gcd_in_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_accepted got=%b expected=0", gcd_in_valid);
        end
        gcd_out_valid = 1'b1;
        gcd_out_data  = 16'h0019;
        @(negedge clk); #1;
        gcd_out_valid = 1'b0;
        checks++;
        if (resp_valid !== 4'b1000 || resp_data !== 16'h0019) begin
            failures++;
            $display("[TB] FAIL stall_resp got=%b/%h expected=1000/0019", resp_valid, resp_data);
        end
        resp_ready = 4'b1000;
        @(negedge clk); #1;
        resp_ready = '0;
        checks++;
        if (done_count !== 16'd6) begin
            failures++;
            $display("[TB] FAIL stall_done_count got=%0d expected=6", done_count);
        end
    endtask

    task automatic test_async_reset();
        req_data[31:0] = 32'h0030_0020;
        req_valid      = 4'b0001;
        @(negedge clk); #1;
        @(negedge clk); #1;
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0000 || resp_valid !== 4'b0000 || resp_data !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL async_reset_resp got=%b/%b/%h expected=0000/0000/0000",
                     req_ready, resp_valid, resp_data);
        end
        checks++;
        if (gcd_in_valid !== 1'b0 || gcd_in_data !== 32'h0 || done_count !== 16'h0) begin
            failures++;
            $display("[TB] FAIL async_reset_engine got=%b/%h/%h expected=0/0/0",
                     gcd_in_valid, gcd_in_data, done_count);
        end
        @(negedge clk);
        reset           = 1'b1;
        req_data[95:64] = 32'h0007_0005;
        req_valid       = 4'b0100;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL async_reset_grant got=%b expected=0100", req_ready);
        end
        do_engine(1);
        req_valid = '0;
        checks++;
        if (resp_valid !== 4'b0100 || resp_data !== 16'h0001) begin
            failures++;
            $display("[TB] FAIL async_reset_resp2 got=%b/%h expected=0100/0001", resp_valid, resp_data);
        end
        resp_ready = 4'b0100;
        @(negedge clk); #1;
        resp_ready = '0;
        checks++;
        if (done_count !== 16'd1) begin
            failures++;
            $display("[TB] FAIL async_reset_done_count got=%0d expected=1", done_count);
        end
    endtask

    task automatic test_count_wrap();
        force dut.done_count_nxt = 16'hFFFF;
        @(negedge clk); #1;
        release dut.done_count_nxt;
        #1;
        checks++;
        if (done_count !== 16'hFFFF) begin
            failures++;
            $display("[TB] FAIL wrap_preload got=%h expected=ffff", done_count);
        end
        req_data[63:32] = 32'h0009_0006;
        req_valid       = 4'b0010;
        #1;
        do_engine(0);
        req_valid = '0;
        checks++;
        if (resp_valid !== 4'b0010 || resp_data !== 16'h0003) begin
            failures++;
            $display("[TB] FAIL wrap_resp got=%b/%h expected=0010/0003", resp_valid, resp_data);
        end
        resp_ready = 4'b0010;
        @(negedge clk); #1;
        resp_ready = '0;
        checks++;
        if (done_count !== 16'h0000) begin
            failures++;
            $display("[TB] FAIL wrap_done_count got=%h expected=0000", done_count);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_engine_stall();
        test_async_reset();
        test_count_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/gcd_arbiter.md
GCD_ARBITER -- requirements
Module: gcd_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters sharing one GCD engine, 2..8.
REQ-002 Parameter W, default 16: operand and result width; request word is 2*W bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset=0 forces the reset state immediately, independent of clk.
REQ-005 req_valid  input  N  per-requester request present.
REQ-006 req_data  input  N*2W  slice i = {a[W-1:0], b[W-1:0]} for requester i, a in the upper half.
REQ-007 req_ready  output  N  one-hot; bit i high = request i accepted this cycle.
REQ-008 resp_valid  output  N  one-hot; bit i high = result for requester i is on resp_data.
REQ-009 resp_data  output  W  result for the requester flagged by resp_valid.
REQ-010 resp_ready  input  N  per-requester result consumed.
REQ-011 gcd_in_valid  output  1  operand pair valid to engine.
REQ-012 gcd_in_data  output  2W  {a,b} to engine.
REQ-013 gcd_in_ready  input  1  engine accepts operands.
REQ-014 gcd_out_valid  input  1  engine result valid (level).
REQ-015 gcd_out_data  input  W  engine result.
REQ-016 done_count  output  16  number of completed responses, wraps 0xFFFF->0x0000.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; one request is in flight at most.
REQ-018 IDLE: grant g SHALL be the first i with req_valid[i]=1 scanning rr_ptr, rr_ptr+1, ... mod N; req_ready[g]=1 combinationally that cycle; at the edge, latch req_data slice g and tag g, go to ISSUE.
REQ-019 IDLE with no req_valid: stay IDLE, req_ready=0.
REQ-020 req_ready SHALL be 0 in every state except IDLE.
REQ-021 ISSUE: gcd_in_valid=1, gcd_in_data=latched pair; on gcd_in_valid & gcd_in_ready go to WAIT; otherwise hold data stable.
REQ-022 gcd_in_valid SHALL be 0 outside ISSUE; gcd_in_data value is don't-care outside ISSUE.
REQ-023 WAIT: on gcd_out_valid=1 latch gcd_out_data into the result register and go to RESP; gcd_out_valid is not sampled in any other state.
REQ-024 RESP: resp_valid[tag]=1 and resp_data=latched result, both held stable until resp_ready[tag]=1; resp_ready of other bits is ignored.
REQ-025 On resp_valid[tag] & resp_ready[tag]: rr_ptr <= (tag+1) mod N, done_count increments, next state IDLE.
REQ-026 Minimum request-to-response latency SHALL be 3 cycles plus engine compute time: accept (IDLE), issue (ISSUE), capture (WAIT), present (RESP).
REQ-027 Operands are passed unmodified; zero operands are forwarded and whatever the engine returns is delivered.
REQ-028 Requester deasserting req_valid before being granted loses no state; grant decisions use only the current cycle's req_valid.
REQ-029 Fairness: with all N requesters continuously valid, each SHALL be served exactly once per N consecutive responses.

Reset
REQ-030 On reset=0: state=IDLE, rr_ptr=0, done_count=0, latched data, tag and result cleared to 0.
REQ-031 During reset all outputs SHALL be 0: req_ready, resp_valid, resp_data, gcd_in_valid, gcd_in_data, done_count.
REQ-032 Reset mid-operation SHALL abandon the in-flight request without response; after release the arbiter starts in IDLE with rr_ptr=0.
REQ-033 First grant may occur in the first rising edge after reset returns to 1.

Verification
REQ-034 Single request: req_valid=0001, req_data[0]=0x0030_0020 -> req_ready=0001 one cycle, later resp_valid=0001, resp_data=0x0010, done_count=1.
REQ-035 Round-robin: all four valid, slices {0x0030_0020, 0x001B_0009, 0x0007_0005, 0x0064_004B}, resp_ready=1111 -> responses in order 0,1,2,3 with data 0x0010, 0x0009, 0x0001, 0x0019; next grant goes to 0.
REQ-036 Backpressure: hold resp_ready=0 for 10 cycles in RESP -> resp_valid and resp_data stable, req_ready stays 0000, gcd_in_valid stays 0.
REQ-037 Engine stall: gcd_in_ready=0 for 5 cycles -> gcd_in_valid=1 with unchanged gcd_in_data until accepted.
REQ-038 Async reset in WAIT: drive reset=0 between edges -> all outputs 0 immediately; after release, requester 2 alone valid is granted and served normally, done_count restarts from 0.
REQ-039 Counter wrap: preload 0xFFFF completions (forced/fast path) then one more -> done_count=0x0000.
